// File: rtl/gameport_pkg.sv
// rtl/gameport_pkg.sv - shared types and constants for the 0x201 game port sequencer
package gameport_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        GAP,
        TIMING
    } gp_state_t;

    localparam logic [15:0] GAMEPORT_ADDR = 16'h0201;

    localparam int P1X = 0;
    localparam int P1Y = 1;
    localparam int P2X = 2;
    localparam int P2Y = 3;
    localparam int NUM_AXES = 4;

endpackage

// File: rtl/gameport_seq_if.sv
// rtl/gameport_seq_if.sv - CPU I/O bus view of the game port (decoded select, strobes, read data)
interface gameport_seq_if;

    logic       cs;
    logic       wr;
    logic       rd;
    logic [7:0] data_out;

    modport master (output cs, output wr, output rd, input data_out);
    modport slave (input cs, input wr, input rd, output data_out);

endinterface

// File: rtl/gameport_axis_timer.sv
// rtl/gameport_axis_timer.sv - one saturating 8-bit axis width counter
module gameport_axis_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       tick,
    input  logic       active,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= 8'h00;
        end else if (tick && active && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/gameport_seq.sv
// rtl/gameport_seq.sv - game port trigger/measure sequencer; GAMEPORT_TIMEOUT_EN masks axis bits after a timeout
module gameport_seq
    import gameport_pkg::*;
#(
    parameter int EN_HOLD   = 4,
    parameter int TICK_DIV  = 220,
    parameter int MAX_TICKS = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    gameport_seq_if.slave        bus,
    input  logic [7:0]           joy_d,
    output logic                 joy_en,
    output logic                 busy,
    output logic                 timeout,
    output logic [31:0]          axis_cnt
);

    localparam int HW = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(MAX_TICKS + 1);

    gp_state_t              state;
    logic [HW-1:0]          hold_cnt;
    logic [PW-1:0]          presc;
    logic [TW-1:0]          tick_cnt;
    logic [NUM_AXES-1:0]    live;
    logic                   write_go;
    logic                   fire_start;
    logic                   tick;
    logic [3:0]             axis_rd;

    assign write_go   = bus.cs && bus.wr;
    // Writes during FIRE/GAP are dropped so the one-shot sees a single clean edge.
    assign fire_start = write_go && (state == IDLE || state == TIMING);
    assign tick       = (state == TIMING) && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            joy_en   <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            presc    <= '0;
            tick_cnt <= '0;
            live     <= '0;
        end else if (fire_start) begin
            state    <= FIRE;
            joy_en   <= 1'b1;
            busy     <= 1'b1;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            presc    <= '0;
            tick_cnt <= '0;
            live     <= '1;
        end else begin
            case (state)
                IDLE: ;
                FIRE: begin
                    if (hold_cnt == HW'(EN_HOLD - 1)) begin
                        joy_en <= 1'b0;
                        state  <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: state <= TIMING;
                TIMING: begin
                    // A lane that has gone low stays dead for the rest of this measurement.
                    live <= live & joy_d[NUM_AXES-1:0];
                    if (joy_d[NUM_AXES-1:0] == '0) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b0;
                    end else if (tick && tick_cnt == TW'(MAX_TICKS - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else if (tick) begin
                        presc    <= '0;
                        tick_cnt <= tick_cnt + 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GAMEPORT_TIMEOUT_EN
    assign axis_rd = timeout ? 4'h0 : joy_d[3:0];
`else
    assign axis_rd = joy_d[3:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out <= 8'h00;
        end else if (bus.cs && bus.rd) begin
            bus.data_out <= {joy_d[7:4], axis_rd};
        end
    end

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_lane
        gameport_axis_timer u_lane (
            .clk    (clk),
            .reset  (reset),
            .clr    (fire_start),
            .tick   (tick),
            .active (live[i] & joy_d[i]),
            .count  (axis_cnt[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_gameport_seq.sv
// tb/tb_gameport_seq.sv - randomized scoreboard bench for gameport_seq
module tb_gameport_seq;

    localparam int EN_HOLD = 4;
    localparam int TD      = 8;
    localparam int MAXT    = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  joy_d = 8'h00;
    logic        joy_en;
    logic        busy;
    logic        timeout;
    logic [31:0] axis_cnt;

    gameport_seq_if bus ();

    gameport_seq #(
        .EN_HOLD   (EN_HOLD),
        .TICK_DIV  (TD),
        .MAX_TICKS (MAXT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .joy_d    (joy_d),
        .joy_en   (joy_en),
        .busy     (busy),
        .timeout  (timeout),
        .axis_cnt (axis_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic        to;
    } meas_t;

    int          errors = 0;
    int          checks = 0;
    meas_t       meas_q[$];
    logic [7:0]  rd_q[$];
    bit          expect_abort = 1'b0;
    bit          model_mask = 1'b0;
    int          rises = 0;
    int          exp_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_read(input logic [7:0] d);
`ifdef GAMEPORT_TIMEOUT_EN
        return model_mask ? {d[7:4], 4'h0} : d;
`else
        return d;
`endif
    endfunction

    // Each lane is high for len[i] clocks of the TIMING window; ticks land on every TD-th clock.
    function automatic meas_t model(input int len[4]);
        meas_t m;
        int    lmax = 0;
        int    t;
        for (int i = 0; i < 4; i++) if (len[i] > lmax) lmax = len[i];
        m.to  = (lmax > MAXT * TD - 1);
        m.cnt = 32'h0;
        for (int i = 0; i < 4; i++) begin
            t = len[i] / TD;
            if (t > MAXT) t = MAXT;
            if (t > 255) t = 255;
            m.cnt[8*i +: 8] = t[7:0];
        end
        return m;
    endfunction

    function automatic int exit_index(input int len[4]);
        int lmax = 0;
        for (int i = 0; i < 4; i++) if (len[i] > lmax) lmax = len[i];
        return (lmax > MAXT * TD - 1) ? MAXT * TD - 1 : lmax;
    endfunction

    task automatic do_read(input logic [7:0] d);
        joy_d = d;
        bus.cs = 1'b1;
        bus.rd = 1'b1;
        rd_q.push_back(exp_read(d));
        step();
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        step();
    endtask

    // Write, then play the datapath through FIRE and GAP; returns at TIMING clock 0.
    task automatic fire(input bit extra_wr, input bit with_rd, input int len[4]);
        joy_d[7:4] = 4'($urandom);
        if (with_rd) begin
            bus.rd = 1'b1;
            rd_q.push_back(exp_read(joy_d));
        end
        bus.cs = 1'b1;
        bus.wr = 1'b1;
        step();
        bus.cs = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        exp_rises++;
        model_mask = 1'b0;
        check("axis_clr", axis_cnt, 32'h0);
        check("busy_on", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 4; i++) joy_d[i] = (len[i] > 0);
        for (int k = 0; k < 20 && joy_en; k++) begin
            if (extra_wr && k == 1) begin
                bus.cs = 1'b1;
                bus.wr = 1'b1;
            end
            step();
            bus.cs = 1'b0;
            bus.wr = 1'b0;
        end
        if (joy_en) fail("joy_en_stuck");
        step();
    endtask

    task automatic timing(input int len[4], input int stop_at, input bit rd_rand);
        meas_t m;
        int    j;
        m = model(len);
        if (stop_at < 0) meas_q.push_back(m);
        for (j = 0; j <= MAXT * TD + 5; j++) begin
            if (j == stop_at) return;
            for (int i = 0; i < 4; i++) joy_d[i] = (j < len[i]);
            if (rd_rand && $urandom_range(0, 15) == 0) begin
                bus.cs = 1'b1;
                bus.rd = 1'b1;
                rd_q.push_back(exp_read(joy_d));
            end
            step();
            bus.cs = 1'b0;
            bus.rd = 1'b0;
            if (!busy) break;
        end
        check("exit_index", j, exit_index(len));
        model_mask = m.to;
        step();
    endtask

    initial begin : monitor
        logic  busy_p;
        logic  en_p;
        logic  rd_p;
        int    en_len;
        meas_t m;
        busy_p = 1'b0;
        en_p   = 1'b0;
        rd_p   = 1'b0;
        en_len = 0;
        forever begin
            @(negedge clk);
            if (rd_p) begin
                if (rd_q.size() == 0) fail("read_without_expectation");
                else check("data_out", {24'h0, bus.data_out}, {24'h0, rd_q.pop_front()});
            end
            rd_p = bus.cs && bus.rd && !reset;
            if (joy_en) begin
                if (!en_p) rises++;
                en_len++;
            end else if (en_p) begin
                check("joy_en_len", en_len, EN_HOLD);
                en_len = 0;
            end
            if (busy_p && !busy) begin
                if (expect_abort) expect_abort = 1'b0;
                else if (meas_q.size() == 0) fail("busy_fall_unexpected");
                else begin
                    m = meas_q.pop_front();
                    check("axis_cnt", axis_cnt, m.cnt);
                    check("timeout", {31'h0, timeout}, {31'h0, m.to});
                end
            end
            busy_p = busy;
            en_p   = joy_en;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time budget exceeded");
        $fatal(1);
    end

    initial begin : stimulus
        int l[4];
        int l2[4];
        bus.cs = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_joy_en", {31'h0, joy_en}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_timeout", {31'h0, timeout}, 32'h0);
        check("rst_axis", axis_cnt, 32'h0);
        check("rst_data", {24'h0, bus.data_out}, 32'h0);

        l = '{100 * TD, 100 * TD, 100 * TD, 100 * TD};
        fire(1'b0, 1'b0, l);
        timing(l, -1, 1'b0);

        l = '{10 * TD, 20 * TD, 30 * TD, 40 * TD};
        fire(1'b0, 1'b0, l);
        timing(l, -1, 1'b1);

        l = '{0, 0, 0, 100000};
        fire(1'b0, 1'b0, l);
        timing(l, -1, 1'b0);
        do_read(8'hFF);
        do_read(8'h38);

        // Read and write on the same clock after a timeout: read sees the pre-write state.
        l = '{MAXT * TD - 1, 3, 0, MAXT * TD - 1};
        fire(1'b0, 1'b1, l);
        timing(l, -1, 1'b0);
        do_read(8'h0F);

        l  = '{200 * TD, 200 * TD, 200 * TD, 200 * TD};
        l2 = '{5 * TD + 3, 7 * TD, 0, 12 * TD};
        fire(1'b0, 1'b0, l);
        timing(l, 50 * TD, 1'b0);
        fire(1'b0, 1'b0, l2);
        timing(l2, -1, 1'b0);

        l = '{9 * TD, 2 * TD, 6 * TD + 1, TD - 1};
        fire(1'b1, 1'b0, l);
        timing(l, -1, 1'b0);

        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < 4; i++) l[i] = $urandom_range(0, 60 * TD + 7);
            if ($urandom_range(0, 4) == 0) l[$urandom_range(0, 3)] = $urandom_range(MAXT * TD - 3, MAXT * TD + 20);
            fire(1'b0, $urandom_range(0, 3) == 0, l);
            timing(l, -1, 1'b1);
            do_read(8'($urandom));
        end

        l = '{100 * TD, 100 * TD, 100 * TD, 100 * TD};
        fire(1'b0, 1'b0, l);
        timing(l, 30 * TD, 1'b0);
        expect_abort = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_mask = 1'b0;
        check("abort_joy_en", {31'h0, joy_en}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_timeout", {31'h0, timeout}, 32'h0);
        check("abort_axis", axis_cnt, 32'h0);
        check("abort_data", {24'h0, bus.data_out}, 32'h0);
        do_read(8'hA5);

        step();
        step();
        check("joy_en_rises", rises, exp_rises);
        check("meas_q_drained", meas_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
